// File: rtl/vend_controller_if.sv
// rtl/vend_controller_if.sv - vend controller signal bundle
// Purpose: groups the accumulator-facing inputs and the controller outputs.
// Ports (signals):
//   money, price   : 16-bit BCD credit and item price (4 digits, [3:0] = ones)
//   buy, cancel    : level-sensitive purchase / refund requests
//   state          : 3-bit controller state, read by the accumulator
//   change         : 16-bit BCD change or refund amount
//   dispense, deny, refund : registered, mutually exclusive result pulses
//   bcd_err        : sticky flag, last snapshot held a digit > 9
// Modports: master drives requests and observes results; slave is the controller.
interface vend_controller_if;
  logic [15:0] money;
  logic [15:0] price;
  logic        buy;
  logic        cancel;
  logic [2:0]  state;
  logic [15:0] change;
  logic        dispense;
  logic        deny;
  logic        refund;
  logic        bcd_err;

  modport master (
    output money, price, buy, cancel,
    input  state, change, dispense, deny, refund, bcd_err
  );

  modport slave (
    input  money, price, buy, cancel,
    output state, change, dispense, deny, refund, bcd_err
  );
endinterface

// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - vend decision, digit-serial BCD change, result pulses
// Purpose: snapshots credit/price on a request, decides vend/deny/refund,
//          subtracts price from credit one BCD digit per cycle, and holds the
//          selected result pulse for HOLD_CYCLES cycles.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : vend_controller_if.slave (money, price, buy, cancel in;
//           state, change, dispense, deny, refund, bcd_err out)
module vend_controller #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input logic              clk,
  input logic              reset,
  vend_controller_if.slave bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CHECK    = 3'd1;
  localparam logic [2:0] S_SUB      = 3'd2;
  localparam logic [2:0] S_DISPENSE = 3'd3;
  localparam logic [2:0] S_DENY     = 3'd4;
  localparam logic [2:0] S_REFUND   = 3'd5;
  localparam logic [2:0] S_WAIT_REL = 3'd6;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] change_q, change_d;
  logic [15:0] money_snap_q, money_snap_d;
  logic [15:0] price_snap_q, price_snap_d;
  logic [1:0]  idx_q, idx_d;
  logic        borrow_q, borrow_d;
  logic [7:0]  hold_q, hold_d;
  logic        dispense_q, dispense_d;
  logic        deny_q, deny_d;
  logic        refund_q, refund_d;
  logic        bcd_err_q, bcd_err_d;

  // Digit-serial subtraction datapath for the digit selected by idx_q.
  logic [3:0] shamt;
  logic [3:0] m_dig, p_dig, res_dig;
  logic [4:0] diff;

  function automatic logic has_bad_digit(input logic [15:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  always_comb begin
    shamt = {idx_q, 2'b00};
    m_dig = 4'(money_snap_q >> shamt);
    p_dig = 4'(price_snap_q >> shamt);
    // 5-bit wrap: bit 4 set means the digit went negative.
    diff    = {1'b0, m_dig} - {1'b0, p_dig} - {4'b0000, borrow_q};
    res_dig = diff[4] ? 4'(diff + 5'd10) : diff[3:0];
  end

  always_comb begin
    state_d      = state_q;
    change_d     = change_q;
    money_snap_d = money_snap_q;
    price_snap_d = price_snap_q;
    idx_d        = idx_q;
    borrow_d     = borrow_q;
    hold_d       = hold_q;
    dispense_d   = 1'b0;
    deny_d       = 1'b0;
    refund_d     = 1'b0;
    bcd_err_d    = bcd_err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.buy) begin
          money_snap_d = bus.money;
          price_snap_d = bus.price;
          bcd_err_d    = 1'b0;
          state_d      = S_CHECK;
        end else if (bus.cancel && (bus.money != 16'h0000)) begin
          money_snap_d = bus.money;
          change_d     = bus.money;
          bcd_err_d    = 1'b0;
          hold_d       = 8'd0;
          refund_d     = 1'b1;
          state_d      = S_REFUND;
        end
      end

      S_CHECK: begin
        if (has_bad_digit(money_snap_q) || has_bad_digit(price_snap_q)) begin
          bcd_err_d = 1'b1;
          deny_d    = 1'b1;
          hold_d    = 8'd0;
          state_d   = S_DENY;
        end else if (money_snap_q >= price_snap_q) begin
          idx_d    = 2'd0;
          borrow_d = 1'b0;
          state_d  = S_SUB;
        end else begin
          deny_d  = 1'b1;
          hold_d  = 8'd0;
          state_d = S_DENY;
        end
      end

      S_SUB: begin
        change_d = (change_q & ~(16'h000F << shamt)) | (16'(res_dig) << shamt);
        borrow_d = diff[4];
        if (idx_q == 2'd3) begin
          dispense_d = 1'b1;
          hold_d     = 8'd0;
          state_d    = S_DISPENSE;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end

      // The pulse is raised on the entering edge, so HOLD_LAST more edges
      // give exactly HOLD_CYCLES asserted cycles.
      S_DISPENSE, S_DENY, S_REFUND: begin
        if (hold_q == HOLD_LAST) begin
          state_d = S_WAIT_REL;
        end else begin
          hold_d     = hold_q + 8'd1;
          dispense_d = (state_q == S_DISPENSE);
          deny_d     = (state_q == S_DENY);
          refund_d   = (state_q == S_REFUND);
        end
      end

      S_WAIT_REL: begin
        if (!bus.buy && !bus.cancel) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      change_q     <= 16'h0000;
      money_snap_q <= 16'h0000;
      price_snap_q <= 16'h0000;
      idx_q        <= 2'd0;
      borrow_q     <= 1'b0;
      hold_q       <= 8'd0;
      dispense_q   <= 1'b0;
      deny_q       <= 1'b0;
      refund_q     <= 1'b0;
      bcd_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      change_q     <= change_d;
      money_snap_q <= money_snap_d;
      price_snap_q <= price_snap_d;
      idx_q        <= idx_d;
      borrow_q     <= borrow_d;
      hold_q       <= hold_d;
      dispense_q   <= dispense_d;
      deny_q       <= deny_d;
      refund_q     <= refund_d;
      bcd_err_q    <= bcd_err_d;
    end
  end

  assign bus.state    = state_q;
  assign bus.change   = change_q;
  assign bus.dispense = dispense_q;
  assign bus.deny     = deny_q;
  assign bus.refund   = refund_q;
  assign bus.bcd_err  = bcd_err_q;

endmodule

// File: tb/tb_vend_controller.sv
// tb/tb_vend_controller.sv - directed self-checking bench for vend_controller
module tb_vend_controller;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  vend_controller_if vif ();

  vend_controller #(.HOLD_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (vif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] pulse_kind();
    if (vif.dispense) return 2'd1;
    if (vif.deny)     return 2'd2;
    if (vif.refund)   return 2'd3;
    return 2'd0;
  endfunction

  // kind: 1 = dispense, 2 = deny, 3 = refund. Latency is counted in edges
  // after the request edge until the pulse is first seen.
  task automatic do_txn(input string tag, input logic [15:0] m, input logic [15:0] p,
                        input logic b, input logic c, input logic hold_btn,
                        input logic [1:0] kind, input logic [15:0] exp_change,
                        input logic exp_err);
    int n;
    int w;
    int exp_lat;
    logic [2:0] exp_first;
    exp_lat   = (kind == 2'd1) ? 5 : (kind == 2'd2) ? 1 : 0;
    exp_first = (kind == 2'd3) ? 3'd5 : 3'd1;
    vif.money  = m;
    vif.price  = p;
    vif.buy    = b;
    vif.cancel = c;
    step();
    check({tag, ".first_state"}, 16'(vif.state), 16'(exp_first));
    if (!hold_btn) begin
      vif.buy    = 1'b0;
      vif.cancel = 1'b0;
    end
    n = 0;
    while (pulse_kind() == 2'd0 && n < 20) begin
      step();
      n++;
    end
    check({tag, ".latency"}, 16'(n), 16'(exp_lat));
    check({tag, ".kind"}, 16'(pulse_kind()), 16'(kind));
    check({tag, ".onehot"}, 16'(int'(vif.dispense) + int'(vif.deny) + int'(vif.refund)), 16'd1);
    check({tag, ".change"}, vif.change, exp_change);
    check({tag, ".bcd_err"}, 16'(vif.bcd_err), 16'(exp_err));
    w = 0;
    while (pulse_kind() != 2'd0 && w < 20) begin
      w++;
      step();
    end
    check({tag, ".width"}, 16'(w), 16'd4);
    check({tag, ".change_hold"}, vif.change, exp_change);
    check({tag, ".wait_rel"}, 16'(vif.state), 16'd6);
    if (hold_btn) begin
      step();
      step();
      check({tag, ".held"}, 16'(vif.state), 16'd6);
      vif.buy    = 1'b0;
      vif.cancel = 1'b0;
    end
    step();
    check({tag, ".idle"}, 16'(vif.state), 16'd0);
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    reset      = 1'b1;
    vif.money  = 16'h0000;
    vif.price  = 16'h0000;
    vif.buy    = 1'b0;
    vif.cancel = 1'b0;
    step();
    check("rst.state", 16'(vif.state), 16'd0);
    check("rst.change", vif.change, 16'h0000);
    check("rst.pulses", {12'd0, vif.dispense, vif.deny, vif.refund, vif.bcd_err}, 16'h0000);
    reset = 1'b0;
    step();

    do_txn("t1", 16'h0125, 16'h0075, 1'b1, 1'b0, 1'b0, 2'd1, 16'h0050, 1'b0);
    do_txn("t2", 16'h1000, 16'h0001, 1'b1, 1'b0, 1'b0, 2'd1, 16'h0999, 1'b0);
    do_txn("t3", 16'h0050, 16'h0075, 1'b1, 1'b0, 1'b1, 2'd2, 16'h0999, 1'b0);
    do_txn("t4", 16'h0250, 16'h0250, 1'b1, 1'b0, 1'b0, 2'd1, 16'h0000, 1'b0);
    do_txn("t5", 16'h00A0, 16'h0010, 1'b1, 1'b0, 1'b0, 2'd2, 16'h0000, 1'b1);
    do_txn("t6", 16'h0300, 16'h0100, 1'b1, 1'b0, 1'b0, 2'd1, 16'h0200, 1'b0);
    do_txn("t7", 16'h0340, 16'h0000, 1'b0, 1'b1, 1'b0, 2'd3, 16'h0340, 1'b0);

    vif.money  = 16'h0000;
    vif.cancel = 1'b1;
    step();
    step();
    check("t8.state", 16'(vif.state), 16'd0);
    check("t8.refund", 16'(vif.refund), 16'd0);
    vif.cancel = 1'b0;
    step();

    do_txn("t9", 16'h0500, 16'h0125, 1'b1, 1'b1, 1'b0, 2'd1, 16'h0375, 1'b0);

    vif.money = 16'h0125;
    vif.price = 16'h0075;
    vif.buy   = 1'b1;
    step();
    vif.buy = 1'b0;
    step();
    step();
    step();
    check("t10.in_sub", 16'(vif.state), 16'd2);
    #2;
    reset = 1'b1;
    #1;
    check("t10.rst_state", 16'(vif.state), 16'd0);
    check("t10.rst_change", vif.change, 16'h0000);
    check("t10.rst_pulses", {13'd0, vif.dispense, vif.deny, vif.refund}, 16'h0000);
    step();
    reset = 1'b0;
    step();

    do_txn("t11", 16'h0125, 16'h0075, 1'b1, 1'b0, 1'b0, 2'd1, 16'h0050, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
- Transaction controller directly downstream of the four-digit BCD money accumulator.
- Consumes the 16-bit BCD credit and a 16-bit BCD item price. Decides on a vend, computes change by digit-serial BCD subtraction, and drives dispense/deny/refund pulses.
- Drives the 3-bit `state` bus that the accumulator uses to gate counting and clearing.

Parameters:
- HOLD_CYCLES, 4: cycles that dispense/deny/refund stay asserted (legal range 1..255).

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high; forces all regs/outputs to reset values immediately
- money  input  16  BCD credit, 4 digits, [3:0] = ones
- price  input  16  BCD item price, same format
- buy  input  1  purchase request, level-sensitive
- cancel  input  1  refund request, level-sensitive
- state  output  3  controller state encoding (consumed by accumulator)
- change  output  16  BCD change/refund amount
- dispense  output  1  vend pulse
- deny  output  1  purchase rejected pulse
- refund  output  1  return-credit pulse
- bcd_err  output  1  sticky flag: last snapshot held a digit >9; cleared on next accepted buy/cancel

Behaviour:
- Reset values:
  - state = IDLE (3'd0); change = 16'h0000.
  - dispense, deny, refund and bcd_err = 0.
  - Snapshot regs, digit index and hold counter = 0.
- State encodings:
  - IDLE = 0, CHECK = 1, SUB = 2, DISPENSE = 3, DENY = 4, REFUND = 5, WAIT_REL = 6.
  - 7 is unused; it returns to IDLE on the next edge.
- IDLE:
  - buy = 1: snapshot money and price, go to CHECK.
  - Else cancel = 1 and money != 0: snapshot money, go to REFUND.
  - buy has priority over cancel when both are high.
  - cancel with money == 0 is ignored.
- CHECK:
  - Any snapshot digit >9: set bcd_err, go to DENY.
  - Else money_snap >= price_snap (plain 16-bit unsigned compare, valid for legal BCD): go to SUB, digit index = 0, borrow = 0.
  - Else go to DENY.
- SUB: one digit per cycle, ones first.
  - d = m_i - p_i - borrow.
  - If d < 0: change digit i = d + 10, borrow = 1. Else change digit i = d, borrow = 0.
  - After digit 3, go to DISPENSE. Final borrow is 0 by construction.
- DISPENSE:
  - dispense = 1 for exactly HOLD_CYCLES cycles.
  - change holds the result and stays stable until the next transaction starts.
  - Then go to WAIT_REL.
- DENY:
  - deny = 1 for HOLD_CYCLES cycles.
  - change is unchanged from its prior value.
  - Then go to WAIT_REL.
- REFUND:
  - change = money_snap on entry.
  - refund = 1 for HOLD_CYCLES cycles, then go to WAIT_REL.
- WAIT_REL:
  - Remain until buy = 0 and cancel = 0, then go to IDLE.
  - This prevents a held button from retriggering.
- Latency: buy sampled at edge 1 → CHECK; edge 2 → SUB; edges 3–6 process digits 0–3; dispense visible after edge 6.
- Ignored inputs:
  - buy and cancel outside IDLE.
  - money/price changes after the snapshot; the snapshot governs the whole transaction.
- Reset mid-operation: all pulses drop immediately (asynchronously), state = IDLE, and any partial change is discarded (change = 0).
- Outputs dispense, deny and refund are registered and mutually exclusive.

Test Plan:
- money=16'h0125, price=16'h0075, buy held 1 cycle → CHECK, SUB; dispense rises after edge 6 and lasts 4 cycles; change=16'h0050; deny=0.
- money=16'h1000, price=16'h0001 → change=16'h0999 (borrow ripple through 3 digits); money=price=16'h0250 → change=16'h0000 with dispense=1.
- money=16'h0050, price=16'h0075 → deny high 4 cycles, dispense=0, change unchanged; buy held high afterward keeps state=6 until released, then state=0.
- money=16'h00A0, price=16'h0010 → bcd_err=1, deny pulse; next valid buy clears bcd_err.
- cancel with money=16'h0340 in IDLE → refund 4 cycles, change=16'h0340; cancel with money=0 → no pulse, state stays 0; buy and cancel together → purchase path taken.
- Assert reset during SUB (after digit 1) → immediately state=0, change=0, all pulses 0; following buy completes normally with correct change.
